// File: rtl/alu_op_encoder.sv
// rtl/alu_op_encoder.sv - instruction word to ALU op encoder with 2-entry skid buffer
module alu_op_encoder #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_insn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_aluop,
  output logic [4:0]           out_shamt,
  output logic [31:0]          out_imm,
  output logic                 out_use_imm,
  output logic                 out_br_ne,
  output logic                 out_br_lt,
  output logic                 out_chk_ovf,
  output logic [31:0]          out_rstatus,
  output logic                 out_multdiv,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  // Major opcodes (insn[31:27])
  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_BNE   = 5'b00010;
  localparam logic [4:0] OPC_ADDI  = 5'b00101;
  localparam logic [4:0] OPC_BLT   = 5'b00110;
  localparam logic [4:0] OPC_SW    = 5'b00111;
  localparam logic [4:0] OPC_LW    = 5'b01000;

  // R-type function codes (insn[6:2])
  localparam logic [4:0] FN_ADD      = 5'b00000;
  localparam logic [4:0] FN_SUB      = 5'b00001;
  localparam logic [4:0] FN_LAST_ALU = 5'b00101;
  localparam logic [4:0] FN_MUL      = 5'b00110;
  localparam logic [4:0] FN_DIV      = 5'b00111;

  // ALU op used by compare-and-branch instructions
  localparam logic [4:0] ALUOP_SUB   = 5'b00001;

  localparam logic [ILL_CNT_W-1:0] ILL_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  // One fully decoded op; this, not the raw word, is what each entry holds
  typedef struct packed {
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        use_imm;
    logic        br_ne;
    logic        br_lt;
    logic        chk_ovf;
    logic [31:0] rstatus;
    logic        multdiv;
    logic        illegal;
  } enc_t;

  logic [4:0] opcode;
  logic [4:0] funct;
  enc_t       enc_in;

  assign opcode = in_insn[31:27];
  assign funct  = in_insn[6:2];

  // insn[26:17] carries nothing this encoder needs
  logic unused_insn_bits;
  assign unused_insn_bits = ^in_insn[26:17];

  // Decode the incoming word; shamt and imm pass through for every opcode
  always_comb begin
    enc_in       = '0;
    enc_in.shamt = in_insn[11:7];
    enc_in.imm   = {{15{in_insn[16]}}, in_insn[16:0]};
    case (opcode)
      OPC_RTYPE: begin
        if (funct <= FN_LAST_ALU) begin
          enc_in.aluop = funct;
        end else if ((funct == FN_MUL) || (funct == FN_DIV)) begin
          enc_in.aluop   = funct;
          enc_in.multdiv = 1'b1;
        end else begin
          enc_in.illegal = 1'b1;
        end
        // Arithmetic that can overflow reports a distinct rstatus code
        case (funct)
          FN_ADD: begin
            enc_in.chk_ovf = 1'b1;
            enc_in.rstatus = 32'd1;
          end
          FN_SUB: begin
            enc_in.chk_ovf = 1'b1;
            enc_in.rstatus = 32'd3;
          end
          FN_MUL: begin
            enc_in.chk_ovf = 1'b1;
            enc_in.rstatus = 32'd4;
          end
          FN_DIV: begin
            enc_in.chk_ovf = 1'b1;
            enc_in.rstatus = 32'd5;
          end
          default: ;
        endcase
      end
      OPC_ADDI: begin
        enc_in.use_imm = 1'b1;
        enc_in.chk_ovf = 1'b1;
        enc_in.rstatus = 32'd2;
      end
      OPC_BNE: begin
        enc_in.aluop = ALUOP_SUB;
        enc_in.br_ne = 1'b1;
      end
      OPC_BLT: begin
        enc_in.aluop = ALUOP_SUB;
        enc_in.br_lt = 1'b1;
      end
      OPC_SW, OPC_LW: begin
        enc_in.use_imm = 1'b1;
      end
      default: ;
    endcase
  end

  // Buffer state
  enc_t                 mem_q [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ILL_CNT_W-1:0] ill_q, ill_d;

  logic push, pop, push_eff, pop_eff;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Flush overrides both sides of the handshake
  assign push_eff  = push & ~flush;
  assign pop_eff   = pop & ~flush;

  // Next-state for occupancy, pointers and the illegal-op counter
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ pop_eff;
    wr_ptr_d = wr_ptr_q ^ push_eff;
    ill_d    = ill_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
    if (push_eff && enc_in.illegal && (ill_q != '1)) begin
      ill_d = ill_q + ILL_ONE;
    end
  end

  // Control registers; the counter survives flush but not reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ill_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ill_q    <= ill_d;
    end
  end

  // Entry storage: encoded op lands in the slot the write pointer names
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push_eff) begin
      mem_q[wr_ptr_q] <= enc_in;
    end
  end

  // Present the head entry; an empty buffer shows all zeros
  enc_t head;
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_aluop   = head.aluop;
  assign out_shamt   = head.shamt;
  assign out_imm     = head.imm;
  assign out_use_imm = head.use_imm;
  assign out_br_ne   = head.br_ne;
  assign out_br_lt   = head.br_lt;
  assign out_chk_ovf = head.chk_ovf;
  assign out_rstatus = head.rstatus;
  assign out_multdiv = head.multdiv;
  assign out_illegal = head.illegal;
  assign ill_count   = ill_q;

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb/tb_alu_op_encoder.sv - scoreboard bench for alu_op_encoder
module tb_alu_op_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_insn = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_aluop;
  logic [4:0]  out_shamt;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_br_ne;
  logic        out_br_lt;
  logic        out_chk_ovf;
  logic [31:0] out_rstatus;
  logic        out_multdiv;
  logic        out_illegal;
  logic [7:0]  ill_count;

  alu_op_encoder #(.ILL_CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_br_ne(out_br_ne), .out_br_lt(out_br_lt),
    .out_chk_ovf(out_chk_ovf), .out_rstatus(out_rstatus),
    .out_multdiv(out_multdiv), .out_illegal(out_illegal), .ill_count(ill_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  logic [7:0] exp_ill = '0;
  logic [79:0] sb[$];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoding, packed as {aluop,shamt,imm,use_imm,br_ne,br_lt,chk_ovf,rstatus,multdiv,illegal}
  function automatic logic [79:0] model(input logic [31:0] w);
    logic [4:0] op;
    logic [4:0] fn;
    logic [4:0] a;
    logic [31:0] im;
    logic [31:0] rs;
    logic ui, ne, lt, ov, md, il;
    op = w[31:27];
    fn = w[6:2];
    a = 5'd0; rs = 32'd0;
    ui = 1'b0; ne = 1'b0; lt = 1'b0; ov = 1'b0; md = 1'b0; il = 1'b0;
    im = w[16] ? (32'hFFFE0000 | {15'd0, w[16:0]}) : {15'd0, w[16:0]};
    if (op == 5'd0) begin
      if (fn < 5'd6) a = fn;
      else if (fn < 5'd8) begin a = fn; md = 1'b1; end
      else il = 1'b1;
      if (fn == 5'd0) begin ov = 1'b1; rs = 32'd1; end
      if (fn == 5'd1) begin ov = 1'b1; rs = 32'd3; end
      if (fn == 5'd6) begin ov = 1'b1; rs = 32'd4; end
      if (fn == 5'd7) begin ov = 1'b1; rs = 32'd5; end
    end else if (op == 5'd5) begin
      ui = 1'b1; ov = 1'b1; rs = 32'd2;
    end else if (op == 5'd2) begin
      a = 5'd1; ne = 1'b1;
    end else if (op == 5'd6) begin
      a = 5'd1; lt = 1'b1;
    end else if (op == 5'd7 || op == 5'd8) begin
      ui = 1'b1;
    end
    return {a, w[11:7], im, ui, ne, lt, ov, rs, md, il};
  endfunction

  logic [79:0] got;
  assign got = {out_aluop, out_shamt, out_imm, out_use_imm, out_br_ne, out_br_lt,
                out_chk_ovf, out_rstatus, out_multdiv, out_illegal};

  // Scoreboard update at the handshake edge
  always @(posedge clock) begin
    if (!reset_n) begin
      sb.delete();
      exp_ill = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        n_pop++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_insn));
        if (model(in_insn) & 80'd1) begin
          if (exp_ill != 8'hFF) exp_ill = exp_ill + 8'd1;
        end
      end
    end
  end

  // Compare the visible head and handshake state every cycle
  always @(negedge clock) begin
    if (reset_n) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, sb.size() != 2);
      check("ill_count", ill_count, exp_ill);
      if (out_valid && sb.size() > 0) check("head", got, sb[0]);
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_insn = w;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("send_timeout", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", out_valid, 0);
  endtask

  logic [31:0] tbl [10] = '{32'h00443000, 32'h2845FFFB, 32'h00443210, 32'h00443024,
                           32'h10008003, 32'h30000004, 32'h38010000, 32'h40000008,
                           32'h00443018, 32'hF800001C};
  int p0;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", got, 0);
    check("rst_ill_count", ill_count, 0);

    // add, addi, sll with a ready consumer
    out_ready = 1'b1;
    send(32'h00443000);
    @(negedge clock);
    check("add_valid", out_valid, 1);
    check("add_aluop", out_aluop, 0);
    check("add_chk_ovf", out_chk_ovf, 1);
    check("add_rstatus", out_rstatus, 1);
    check("add_use_imm", out_use_imm, 0);
    send(32'h2845FFFB);
    @(negedge clock);
    check("addi_use_imm", out_use_imm, 1);
    check("addi_imm", out_imm, 32'hFFFFFFFB);
    check("addi_rstatus", out_rstatus, 2);
    send(32'h00443210);
    @(negedge clock);
    check("sll_aluop", out_aluop, 5'b00100);
    check("sll_shamt", out_shamt, 4);
    check("sll_chk_ovf", out_chk_ovf, 0);
    drain();

    // stall: three back-to-back words into a blocked consumer
    out_ready = 1'b0;
    p0 = n_pop;
    @(negedge clock);
    in_valid = 1'b1; in_insn = 32'h00443000;
    @(negedge clock);
    in_insn = 32'h00443210;
    @(negedge clock);
    in_insn = 32'h10008003;
    check("stall_in_ready", in_ready, 0);
    repeat (3) begin
      @(negedge clock);
      check("stall_hold_rstatus", out_rstatus, 1);
    end
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 20) begin @(negedge clock); n++; end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    drain();
    check("stall_pops", n_pop - p0, 3);

    // flush at count=1 with a concurrent illegal push
    out_ready = 1'b0;
    send(32'h00443000);
    p0 = int'(ill_count);
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_insn = 32'h00443024; out_ready = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("flush1_valid", out_valid, 0);
    check("flush1_ill", ill_count, p0);

    // flush at count=2 with in_valid held
    send(32'h2845FFFB);
    send(32'h30000004);
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_insn = 32'h40000008;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush2_valid", out_valid, 0);
    check("flush2_in_ready", in_ready, 1);
    check("flush2_ill", ill_count, p0);
    out_ready = 1'b1;
    send(32'h38010000);
    drain();

    // random traffic
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_insn = tbl[$urandom_range(0, 9)];
    end
    @(negedge clock);
    in_valid = 1'b0;
    drain();

    // illegal op saturation
    for (int i = 0; i < 300; i++) send(32'h00443024);
    drain();
    check("ill_saturated", ill_count, 8'hFF);
    out_ready = 1'b0;
    send(32'h00443024);
    @(negedge clock);
    check("ill_flag", out_illegal, 1);
    check("ill_aluop", out_aluop, 0);
    check("ill_hold_count", ill_count, 8'hFF);

    // asynchronous reset with one entry waiting
    drain();
    out_ready = 1'b0;
    send(32'h2845FFFB);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_outputs", got, 0);
    check("mid_rst_ill", ill_count, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00443000);
    @(negedge clock);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_rstatus", out_rstatus, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
